conv_row_feeder: RTL
====================

# conv_row_feeder

Upstream feeder for the 3×3×3 convolution PE. It accepts a serial pixel stream, assembles 32-pixel rows in a 4-slot row ring, and replays each 3-row window as a 3-cycle burst on a 32-lane row bus. The row bus drives the PE's `data_in00..31`, `row_valid` drives its `init`, and `row_sel` tells the PE which window row is on the bus.

## Interface
- `WIDTH`, 9, pixel width in bits (same as PE).
- `LANES`, 32, pixels per row (PE input lanes).
- `IMG_ROWS`, 32, rows per frame (≥3).
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset; one clock, reset is asynchronous and active-low.
- `frame_start` input 1: synchronous clear of all frame state.
- `pix_in` input WIDTH: pixel data.
- `pix_valid` input 1: `pix_in` is valid.
- `pix_ready` output 1: feeder can accept a pixel. Combinational from state.
- `pe_ready` input 1: PE accepts the current row beat.
- `row_out` output LANES*WIDTH: row data; lane k = bits [k*WIDTH +: WIDTH] → PE `data_in<k>`.
- `row_valid` output 1: burst beat valid; drives PE `init`.
- `row_sel` output 2: beat index within burst (0 = top, 1 = middle, 2 = bottom).
- `win_row` output $clog2(IMG_ROWS): frame row index of the window's top row.
- `frame_done` output 1: single-cycle pulse after the frame's last burst.

## Operation
- **Pixel acceptance:** a pixel is accepted when `pix_valid && pix_ready`.
  - Each accepted pixel goes to lane `col` of fill slot `wr_slot`.
  - `col` counts 0..LANES-1, with lane 0 as the first pixel of a row.
- **Row completion:** occurs on acceptance at `col == LANES-1`.
  - `col` goes to 0, `wr_slot` advances mod 4, and `rows_in` increments.
- **Burst trigger:** a burst is queued on a completion where the new `rows_in` ≥ 3.
  - Source slots are newest-2, newest-1, newest.
  - `win_row` = new `rows_in` - 3.
- **Burst states:** IDLE → B0 → B1 → B2 → IDLE. In state Bn, `row_valid` = 1, `row_sel` = n, and `row_out` = slot (newest-2+n).
  - A state advances only on a cycle where `pe_ready` = 1.
  - While `pe_ready` = 0, `row_out`, `row_sel` and `win_row` hold stable.
- **Slot safety:** the 4-slot ring keeps the write slot (newest+1) disjoint from the three read slots, so filling continues during a burst.
- **Input backpressure:** `pix_ready` = 0 when `col == LANES-1` and a burst is queued or in progress, or when `frame_start` = 1. Otherwise `pix_ready` = 1.
  - At most one burst is ever outstanding.
- **Frame end:** when `rows_in == IMG_ROWS` and the burst from B2 completes, `frame_done` pulses for one cycle.
  - Then `rows_in`, `col` and `wr_slot` clear to 0; row data is not cleared.
  - A frame yields exactly IMG_ROWS-2 bursts.
- **`frame_start`:** clears `col`, `rows_in`, `wr_slot` and the burst FSM (to IDLE).
  - Any burst in progress is aborted: `row_valid` = 0 from the next cycle.
  - It wins over a simultaneous pixel (the pixel is not accepted) and over a simultaneous burst advance.
  - It suppresses `frame_done`.
- **Reset** (`rst_n` low, asynchronous):
  - FSM IDLE, all counters 0.
  - `row_out` = 0, `row_valid` = 0, `row_sel` = 0, `win_row` = 0, `frame_done` = 0.
  - Row slots cleared to 0; `pix_ready` = 1 once `rst_n` is high.
  - Reset mid-burst or mid-row discards all progress.
- **Arithmetic:** no arithmetic on pixel data; pixels pass through bit-exact. Counter widths are sized to their ranges, and wrap is explicit (slot mod 4, `col` mod LANES).

## Timing
- All outputs except `pix_ready` are registered.
- With the last pixel of row r (r ≥ 2, 0-based) accepted at edge T and `pe_ready` held 1:
  - `row_valid` = 1 and `row_sel` = 0 after T+1;
  - `row_sel` = 1 after T+2 and `row_sel` = 2 after T+3;
  - `row_valid` = 0 after T+4.
  - Latency from last pixel to first beat: 1 cycle.
- Each `pe_ready` = 0 cycle during a burst extends it by one cycle.
- `frame_done` is high for the cycle after the final B2 beat is accepted.
- The next pixel may be accepted at T+1. The last pixel of the next row stalls (`pix_ready` = 0) until the cycle after the B2 beat is accepted.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream → all outputs 0 immediately; `pix_ready` = 1 after release; no `row_valid` until 3 new rows arrive.
- **First window:** stream rows 0, 1, 2 with pixel (r, k) = (r+k)%3, `pe_ready` = 1.
  - No burst after rows 0 and 1.
  - After row 2: 3 beats with `row_sel` 0/1/2, lane k values (k)%3, (1+k)%3, (2+k)%3, and `win_row` = 0, starting 1 cycle after the last pixel.
- **PE backpressure:** `pe_ready` = 0 for 5 cycles during B1 → B1 data is held stable for 6 cycles, then B2 follows, with no data loss.
- **Input stall:** hold `pe_ready` = 0 for 40 cycles while streaming → `pix_ready` drops at lane 31 of the next row; that pixel is accepted the cycle after B2 is accepted, and the next burst's `win_row` increments by 1.
- **Full frame:** continuous 32×32 stream → exactly 30 bursts with `win_row` 0..29, then one `frame_done` pulse; the next frame restarts at `win_row` 0.
- **`frame_start` abort:** assert during B1 together with `pix_valid` → `row_valid` = 0 next cycle, the pixel is not accepted, no `frame_done`, and 3 fresh rows are required before the next burst.

Source files
------------

// File: rtl/conv_row_feeder_if.sv
// Pixel-stream and row-bus signal bundle between a pixel source / PE and conv_row_feeder.
// The slave modport is the feeder's view; the master modport is the source/PE side.
interface conv_row_feeder_if #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned LANES    = 32,
  parameter int unsigned IMG_ROWS = 32
);
  logic                        frame_start;
  logic [WIDTH-1:0]            pix_in;
  logic                        pix_valid;
  logic                        pix_ready;
  logic                        pe_ready;
  logic [LANES*WIDTH-1:0]      row_out;
  logic                        row_valid;
  logic [1:0]                  row_sel;
  logic [$clog2(IMG_ROWS)-1:0] win_row;
  logic                        frame_done;

  modport master (
    output frame_start, pix_in, pix_valid, pe_ready,
    input  pix_ready, row_out, row_valid, row_sel, win_row, frame_done
  );

  modport slave (
    input  frame_start, pix_in, pix_valid, pe_ready,
    output pix_ready, row_out, row_valid, row_sel, win_row, frame_done
  );
endinterface

// File: rtl/conv_row_feeder.sv
// Assembles serial pixels into 32-lane rows in a 4-slot ring and replays each
// 3-row window to the convolution PE as a 3-beat burst (top, middle, bottom).
module conv_row_feeder #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned LANES    = 32,
  parameter int unsigned IMG_ROWS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  conv_row_feeder_if.slave  bus
);
  localparam int unsigned SLOTS    = 4;
  localparam int unsigned COL_W    = $clog2(LANES);
  localparam int unsigned CNT_W    = $clog2(IMG_ROWS + 1);
  localparam int unsigned WIN_W    = $clog2(IMG_ROWS);
  localparam int unsigned ROW_BITS = LANES * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_B2} state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_slot [SLOTS][LANES];
  logic [COL_W-1:0]    r_col;
  logic [1:0]          r_wr_slot;
  logic [1:0]          r_rd_base;
  logic [CNT_W-1:0]    r_rows_in;
  logic                r_pending;
  logic [WIN_W-1:0]    r_win_next;
  logic [ROW_BITS-1:0] r_row_out;
  logic                r_row_valid;
  logic [1:0]          r_row_sel;
  logic [WIN_W-1:0]    r_win_row;
  logic                r_frame_done;

  logic [ROW_BITS-1:0] w_slot_flat [SLOTS];
  logic                w_busy;
  logic                w_pix_ready;
  logic                w_accept;
  logic                w_row_done;
  logic [CNT_W-1:0]    w_rows_next;

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_slot_flat[s][k*WIDTH +: WIDTH] = r_slot[s][k];
    end
  end

  // The row-closing pixel waits while a burst still owns the read slots.
  assign w_busy      = r_pending || (r_state != S_IDLE);
  assign w_pix_ready = !bus.frame_start && !((r_col == COL_W'(LANES - 1)) && w_busy);
  assign w_accept    = bus.pix_valid && w_pix_ready;
  assign w_row_done  = w_accept && (r_col == COL_W'(LANES - 1));
  assign w_rows_next = r_rows_in + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_wr_slot    <= '0;
      r_rd_base    <= '0;
      r_rows_in    <= '0;
      r_pending    <= 1'b0;
      r_win_next   <= '0;
      r_row_out    <= '0;
      r_row_valid  <= 1'b0;
      r_row_sel    <= '0;
      r_win_row    <= '0;
      r_frame_done <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        for (int k = 0; k < LANES; k++) begin
          r_slot[s][k] <= '0;
        end
      end
    end else if (bus.frame_start) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_wr_slot    <= '0;
      r_rows_in    <= '0;
      r_pending    <= 1'b0;
      r_row_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_accept) begin
        r_slot[r_wr_slot][r_col] <= bus.pix_in;
        r_col <= w_row_done ? '0 : r_col + COL_W'(1);
        if (w_row_done) begin
          r_wr_slot <= r_wr_slot + 2'd1;
          r_rows_in <= w_rows_next;
          if (w_rows_next >= CNT_W'(3)) begin
            r_pending  <= 1'b1;
            r_rd_base  <= r_wr_slot - 2'd2;
            r_win_next <= WIN_W'(w_rows_next - CNT_W'(3));
          end
        end
      end

      // Burst sequencer; later frame-end clears override the fill updates above.
      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_state     <= S_B0;
            r_pending   <= 1'b0;
            r_row_valid <= 1'b1;
            r_row_sel   <= 2'd0;
            r_row_out   <= w_slot_flat[r_rd_base];
            r_win_row   <= r_win_next;
          end
        end
        S_B0: begin
          if (bus.pe_ready) begin
            r_state   <= S_B1;
            r_row_sel <= 2'd1;
            r_row_out <= w_slot_flat[r_rd_base + 2'd1];
          end
        end
        S_B1: begin
          if (bus.pe_ready) begin
            r_state   <= S_B2;
            r_row_sel <= 2'd2;
            r_row_out <= w_slot_flat[r_rd_base + 2'd2];
          end
        end
        S_B2: begin
          if (bus.pe_ready) begin
            r_state     <= S_IDLE;
            r_row_valid <= 1'b0;
            if (r_rows_in == CNT_W'(IMG_ROWS)) begin
              r_frame_done <= 1'b1;
              r_col        <= '0;
              r_rows_in    <= '0;
              r_wr_slot    <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pix_ready  = w_pix_ready;
  assign bus.row_out    = r_row_out;
  assign bus.row_valid  = r_row_valid;
  assign bus.row_sel    = r_row_sel;
  assign bus.win_row    = r_win_row;
  assign bus.frame_done = r_frame_done;
endmodule
